counter3: RTL and testbench

// - Free-running 3-bit bounce (up/down) counter: after reset it counts 1,2,...,7,

---
 rtl/counter3_pkg.sv | 13 +
 rtl/counter3.sv | 76 +++++++
 tb/tb_counter3.sv | 125 ++++++++++++
 3 files changed

// File: rtl/counter3_pkg.sv
// Shared defaults and direction type for the bounce counter.
package counter3_pkg;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_CNT_MIN = 1;
    localparam int DEF_CNT_MAX = 7;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter3_pkg

// File: rtl/counter3.sv
// Free-running up/down bounce counter between CNT_MIN and CNT_MAX; each
// turn-around value is held for exactly one cycle.
module counter3
    import counter3_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_MIN = DEF_CNT_MIN,
    parameter int CNT_MAX = DEF_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             dir_up,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(CNT_MIN);
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(CNT_MAX);
    localparam logic [WIDTH-1:0] MIN_P1_V  = WIDTH'(CNT_MIN + 1);
    localparam logic [WIDTH-1:0] MAX_M1_V  = WIDTH'(CNT_MAX - 1);

    generate
        if (!(CNT_MIN >= 0 && CNT_MIN < CNT_MAX && CNT_MAX <= (2 ** WIDTH) - 1)) begin : g_param_check
            $error("counter3: illegal parameters WIDTH=%0d CNT_MIN=%0d CNT_MAX=%0d",
                   WIDTH, CNT_MIN, CNT_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    dir_e             dir_reg;
    dir_e             dir_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= MIN_V;
            dir_reg   <= DIR_UP;
        end else begin
            count_reg <= count_next;
            dir_reg   <= dir_next;
        end
    end

    // Endpoints are decided by count alone, so a stale direction at an
    // endpoint or an out-of-range count is pulled back onto the cycle.
    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        if (count_reg > MAX_V) begin
            count_next = MAX_V;
            dir_next   = DIR_DOWN;
        end else if (count_reg < MIN_V) begin
            count_next = MIN_V;
            dir_next   = DIR_UP;
        end else if (count_reg == MAX_V) begin
            count_next = MAX_M1_V;
            dir_next   = (MAX_M1_V == MIN_V) ? DIR_UP : DIR_DOWN;
        end else if (count_reg == MIN_V) begin
            count_next = MIN_P1_V;
            dir_next   = (MIN_P1_V == MAX_V) ? DIR_DOWN : DIR_UP;
        end else if (dir_reg == DIR_UP) begin
            count_next = count_reg + 1'b1;
            dir_next   = (count_reg + 1'b1 == MAX_V) ? DIR_DOWN : DIR_UP;
        end else begin
            count_next = count_reg - 1'b1;
            dir_next   = (count_reg - 1'b1 == MIN_V) ? DIR_UP : DIR_DOWN;
        end
    end

    assign count  = count_reg;
    assign dir_up = (dir_reg == DIR_UP);
    assign at_max = (count_reg == MAX_V);
    assign at_min = (count_reg == MIN_V);

endmodule : counter3

// File: tb/tb_counter3.sv
// Bench for counter3: default instance plus a WIDTH=4, 3..12 instance, both
// compared against a triangle-wave model indexed by edges since reset.
module tb_counter3;

    logic       clk;
    logic       rst;

    logic [2:0] count_a;
    logic       dir_up_a, at_max_a, at_min_a;
    logic [3:0] count_b;
    logic       dir_up_b, at_max_b, at_min_b;

    int vectors     = 0;
    int miscompares = 0;
    int n_since_rst = 0;
    logic [2:0] prev_a;
    logic [3:0] prev_b;

    counter3 dut_a (
        .clk    (clk),
        .rst    (rst),
        .count  (count_a),
        .dir_up (dir_up_a),
        .at_max (at_max_a),
        .at_min (at_min_a)
    );

    counter3 #(.WIDTH(4), .CNT_MIN(3), .CNT_MAX(12)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .count  (count_b),
        .dir_up (dir_up_b),
        .at_max (at_max_b),
        .at_min (at_min_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d since reset)", tag, obs, exp, n_since_rst);
        end
    endtask

    // Triangle wave: position n steps after reset within a period of 2*span.
    task automatic expect_at(input int n, input int lo, input int hi,
                             output int cnt, output int up);
        int span, p;
        span = hi - lo;
        p    = n % (2 * span);
        cnt  = (p <= span) ? lo + p : lo + 2 * span - p;
        up   = (p < span) ? 1 : 0;
    endtask

    task automatic step(input logic r);
        int ec, eu;
        prev_a = count_a;
        prev_b = count_b;
        rst = r;
        @(posedge clk);
        #1;
        n_since_rst = r ? 0 : n_since_rst + 1;

        expect_at(n_since_rst, 1, 7, ec, eu);
        chk("a_count",  32'(count_a),  32'(ec));
        chk("a_dir_up", 32'(dir_up_a), 32'(eu));
        chk("a_at_max", 32'(at_max_a), 32'(ec == 7));
        chk("a_at_min", 32'(at_min_a), 32'(ec == 1));

        expect_at(n_since_rst, 3, 12, ec, eu);
        chk("b_count",  32'(count_b),  32'(ec));
        chk("b_dir_up", 32'(dir_up_b), 32'(eu));
        chk("b_at_max", 32'(at_max_b), 32'(ec == 12));
        chk("b_at_min", 32'(at_min_b), 32'(ec == 3));

        if (!r) begin
            chk("a_no_repeat", 32'(count_a != prev_a), 32'd1);
            chk("b_no_repeat", 32'(count_b != prev_b), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;

        // Reset hold for two edges.
        step(1'b1);
        step(1'b1);
        chk("reset_count", 32'(count_a), 32'd1);

        // Up ramp to 7, then down ramp to 1 and back to 2.
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("peak_a", 32'(count_a), 32'd7);
        chk("peak_dir_a", 32'(dir_up_a), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("floor_a", 32'(count_a), 32'd1);
        step(1'b0);
        chk("rebound_a", 32'(count_a), 32'd2);

        // Long run: five default periods (covers >3 periods of the 18-cycle variant).
        for (int i = 0; i < 60; i++) step(1'b0);

        // Mid-sequence reset while descending at 5.
        step(1'b1);
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("mid_pre_a", 32'(count_a), 32'd5);
        chk("mid_pre_dir_a", 32'(dir_up_a), 32'd0);
        step(1'b1);
        chk("mid_rst_a", 32'(count_a), 32'd1);
        chk("mid_rst_dir_a", 32'(dir_up_a), 32'd1);
        step(1'b0);
        chk("mid_rel_a", 32'(count_a), 32'd2);

        // Randomized reset pulses over a long stretch.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_counter3
